// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage behind the PC stage.
//
// Issues at most one outstanding instruction-memory request for the current
// fetch PC, buffers each returned word with its PC in a small FIFO, and hands
// {pc, instr, misalign} to decode over a valid/ready handshake. A misaligned
// PC produces a FIFO entry directly, without a memory access. A branch
// redirect flushes the FIFO and discards the response still in flight.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   pc_in, taken_br          fetch PC and redirect from the PC stage
//   pc_hold                  PC stage must keep its PC next edge
//   imem_req_valid/ready     request handshake, imem_req_addr = fetch address
//   imem_rsp_valid/data      response word (cannot be back-pressured)
//   id_valid/ready           decode handshake
//   id_pc, id_instr          head entry PC and instruction word
//   id_misalign              head entry is a misaligned-fetch exception
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            taken_br,
    output logic            pc_hold,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_misalign
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            active_q;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_mem_q    [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem_d    [FIFO_DEPTH];
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [31:0]     instr_mem_d [FIFO_DEPTH];
    logic            mis_mem_q   [FIFO_DEPTH];
    logic            mis_mem_d   [FIFO_DEPTH];

    logic issue_ok, req_fire, mis_push, rsp_push, push, pop;

    // active_q keeps the request/hold outputs at their reset values during
    // reset and for the first cycle after release, since both depend on inputs.
    assign issue_ok = active_q && (state_q == ST_RUN) &&
                      (count_q < CW'(FIFO_DEPTH)) && !taken_br;
    assign imem_req_valid = issue_ok && (pc_in[1:0] == 2'b00);
    assign imem_req_addr  = pc_in;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign mis_push       = issue_ok && (pc_in[1:0] != 2'b00);
    assign rsp_push       = (state_q == ST_WAIT) && imem_rsp_valid && !taken_br;
    assign push           = mis_push || rsp_push;
    assign pop            = id_valid && id_ready;

    assign pc_hold     = !(active_q && (req_fire || mis_push || taken_br));
    assign id_valid    = (count_q != '0);
    assign id_pc       = pc_mem_q[rd_ptr_q];
    assign id_instr    = instr_mem_q[rd_ptr_q];
    assign id_misalign = mis_mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        mis_mem_d   = mis_mem_q;

        if (push) begin
            pc_mem_d[wr_ptr_q]    = mis_push ? pc_in : pend_pc_q;
            instr_mem_d[wr_ptr_q] = mis_push ? 32'h0 : imem_rsp_data;
            mis_mem_d[wr_ptr_q]   = mis_push;
        end

        // Flush wins over push and pop.
        if (taken_br) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        case (state_q)
            ST_RUN: begin
                if (req_fire) begin
                    pend_pc_d = pc_in;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid)  state_d = ST_RUN;
                else if (taken_br)   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (imem_rsp_valid)  state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            pend_pc_q <= '0;
            active_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
                mis_mem_q[i]   <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            pend_pc_q   <= pend_pc_d;
            active_q    <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            mis_mem_q   <= mis_mem_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed, table-driven bench for if_fetch.
// Each table row is one clock cycle: inputs are applied after the falling
// edge, outputs are compared 1 ns later, and the rising edge then commits.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        taken_br;
    logic        pc_hold;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_fetch #(.XLEN(32), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .taken_br       (taken_br),
        .pc_hold        (pc_hold),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_misalign    (id_misalign)
    );

    typedef struct {
        logic [31:0] pc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        br;
        logic        idr;
        logic        e_rqv;
        logic        e_hold;
        logic        e_idv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    function automatic vec_t mk(logic [31:0] pc, logic rdy, logic rv, logic [31:0] rd,
                                logic br, logic idr, logic e_rqv, logic e_hold,
                                logic e_idv, logic [31:0] e_pc, logic [31:0] e_instr,
                                logic e_mis);
        vec_t v;
        v.pc = pc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.br = br; v.idr = idr;
        v.e_rqv = e_rqv; v.e_hold = e_hold; v.e_idv = e_idv;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic br, input logic idr);
        pc_in = pc; imem_req_ready = rdy; imem_rsp_valid = rv;
        imem_rsp_data = rd; taken_br = br; id_ready = idr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, ".pc_hold"},   {31'b0, pc_hold},        32'd1);
        check({tag, ".id_valid"},  {31'b0, id_valid},       32'd0);
        check({tag, ".id_pc"},     id_pc,                   32'h0);
        check({tag, ".id_instr"},  id_instr,                32'h0);
        check({tag, ".id_mis"},    {31'b0, id_misalign},    32'd0);
    endtask

    vec_t vecs[24];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 0: fetch PC 0; 1: response; 2-8: fill to two entries, stray RUN
        // response ignored, drain; 9-12: redirect in WAIT, response two cycles
        // later dropped; 13-15: fetch 0x100; 16: redirect with coincident
        // response; 17-21: fetch 0x200 then misaligned 0x102; 22-23: flush
        // of a non-empty FIFO.
        vecs[0]  = mk(32'h000, 1, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0,   32'h0,        0);
        vecs[1]  = mk(32'h004, 1, 1, 32'h00500093, 0, 1, 0, 1, 0, 32'h0,   32'h0,        0);
        vecs[2]  = mk(32'h004, 1, 0, 32'h0,        0, 0, 1, 0, 1, 32'h0,   32'h00500093, 0);
        vecs[3]  = mk(32'h008, 1, 1, 32'h00A00113, 0, 0, 0, 1, 1, 32'h0,   32'h00500093, 0);
        vecs[4]  = mk(32'h008, 1, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0,   32'h00500093, 0);
        vecs[5]  = mk(32'h008, 1, 1, 32'hDEADBEEF, 0, 0, 0, 1, 1, 32'h0,   32'h00500093, 0);
        vecs[6]  = mk(32'h008, 1, 0, 32'h0,        0, 1, 0, 1, 1, 32'h0,   32'h00500093, 0);
        vecs[7]  = mk(32'h008, 0, 0, 32'h0,        0, 1, 1, 1, 1, 32'h4,   32'h00A00113, 0);
        vecs[8]  = mk(32'h008, 1, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0,   32'h0,        0);
        vecs[9]  = mk(32'h00C, 1, 0, 32'h0,        1, 1, 0, 0, 0, 32'h0,   32'h0,        0);
        vecs[10] = mk(32'h100, 1, 0, 32'h0,        0, 1, 0, 1, 0, 32'h0,   32'h0,        0);
        vecs[11] = mk(32'h100, 1, 1, 32'hDEADBEEF, 0, 1, 0, 1, 0, 32'h0,   32'h0,        0);
        vecs[12] = mk(32'h100, 1, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0,   32'h0,        0);
        vecs[13] = mk(32'h104, 1, 1, 32'h11111111, 0, 1, 0, 1, 0, 32'h0,   32'h0,        0);
        vecs[14] = mk(32'h104, 0, 0, 32'h0,        0, 0, 1, 1, 1, 32'h100, 32'h11111111, 0);
        vecs[15] = mk(32'h104, 1, 0, 32'h0,        0, 1, 1, 0, 1, 32'h100, 32'h11111111, 0);
        vecs[16] = mk(32'h108, 1, 1, 32'h22222222, 1, 1, 0, 0, 0, 32'h0,   32'h0,        0);
        vecs[17] = mk(32'h200, 1, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0,   32'h0,        0);
        vecs[18] = mk(32'h204, 1, 1, 32'h33333333, 0, 1, 0, 1, 0, 32'h0,   32'h0,        0);
        vecs[19] = mk(32'h102, 1, 0, 32'h0,        0, 0, 0, 0, 1, 32'h200, 32'h33333333, 0);
        vecs[20] = mk(32'h104, 1, 0, 32'h0,        0, 1, 0, 1, 1, 32'h200, 32'h33333333, 0);
        vecs[21] = mk(32'h104, 0, 0, 32'h0,        0, 0, 1, 1, 1, 32'h102, 32'h0,        1);
        vecs[22] = mk(32'h104, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h102, 32'h0,        1);
        vecs[23] = mk(32'h104, 0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,   32'h0,        0);

        rst = 1'b0;
        drive(32'h0, 1, 0, 32'h0, 0, 1);
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].br, vecs[i].idr);
            #1;
            check($sformatf("v%0d.req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_rqv});
            check($sformatf("v%0d.pc_hold", i),   {31'b0, pc_hold},        {31'b0, vecs[i].e_hold});
            check($sformatf("v%0d.id_valid", i),  {31'b0, id_valid},       {31'b0, vecs[i].e_idv});
            if (vecs[i].e_rqv)
                check($sformatf("v%0d.req_addr", i), imem_req_addr, vecs[i].pc);
            if (vecs[i].e_idv) begin
                check($sformatf("v%0d.id_pc", i),    id_pc,    vecs[i].e_pc);
                check($sformatf("v%0d.id_instr", i), id_instr, vecs[i].e_instr);
                check($sformatf("v%0d.id_mis", i),   {31'b0, id_misalign}, {31'b0, vecs[i].e_mis});
            end
        end

        // Reset asserted while a request is outstanding with an entry buffered.
        @(negedge clk); drive(32'h040, 1, 0, 32'h0,        0, 0);
        @(negedge clk); drive(32'h044, 1, 1, 32'h44444444, 0, 0);
        @(negedge clk); drive(32'h044, 1, 0, 32'h0,        0, 0);
        #1;
        check("rstw.pre_id_valid", {31'b0, id_valid}, 32'd1);
        check("rstw.pre_id_pc",    id_pc,             32'h40);
        check("rstw.pre_id_instr", id_instr,          32'h44444444);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rstw");
        repeat (2) @(negedge clk);
        // Release with a stray response from the aborted request.
        rst = 1'b1;
        drive(32'h080, 1, 1, 32'h66666666, 0, 0);
        #1;
        check("rel.req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rel.pc_hold",   {31'b0, pc_hold},        32'd1);
        @(negedge clk); drive(32'h080, 1, 0, 32'h0, 0, 0);
        #1;
        check("rel.stray_id_valid", {31'b0, id_valid},       32'd0);
        check("rel.req_valid2",     {31'b0, imem_req_valid}, 32'd1);
        check("rel.req_addr",       imem_req_addr,           32'h80);
        check("rel.pc_hold2",       {31'b0, pc_hold},        32'd0);
        @(negedge clk); drive(32'h084, 1, 1, 32'h55555555, 0, 0);
        @(negedge clk); drive(32'h084, 0, 0, 32'h0,        0, 0);
        #1;
        check("rel.id_valid", {31'b0, id_valid},    32'd1);
        check("rel.id_pc",    id_pc,                32'h80);
        check("rel.id_instr", id_instr,             32'h55555555);
        check("rel.id_mis",   {31'b0, id_misalign}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
